// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port synchronous-read memory between fetch (IF) and memory stage (DM).
// Latency: grant is combinational from req; read data returns MEM_LAT cycles after the grant.
// Backpressure: req is held until gnt; stall_fetch/stall_mem hold the pipeline while denied or awaiting data.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch,
    output logic              stall_mem
);

    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              owner, owner_nxt;      // 1 = DM owns the outstanding read, 0 = IF
    logic [SW-1:0]     starve_cnt, starve_nxt;

    logic completion;
    logic window;
    logic if_force;

    // Register the FSM state, latency counter, owner tag and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant decision, memory mux, read-data routing, stalls and next-state logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        owner_nxt   = owner;
        starve_nxt  = starve_cnt;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if_rvalid   = 1'b0;
        dm_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rdata    = '0;

        completion = (state == RD_WAIT) && (cnt == CNT_W'(1));
        // A new access may only start when the port is free or the pending read is retiring.
        window     = (state == IDLE) || completion;
        // A starved fetch overrides the normal DM-first priority.
        if_force   = (starve_cnt == SW'(STARVE_MAX));

        if (!rst && window) begin
            if (if_req && (!dm_req || if_force)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end

        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end

        if (!rst && completion) begin
            if (owner) begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end

        stall_fetch = (if_req && !if_gnt) || ((state == RD_WAIT) && !owner && !if_rvalid);
        stall_mem   = (dm_req && !dm_gnt) || ((state == RD_WAIT) && owner && !dm_rvalid);

        // A read grant (re)loads the wait window; writes leave no transaction outstanding.
        if (if_gnt || (dm_gnt && !dm_we)) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = CNT_W'(MEM_LAT);
            owner_nxt = dm_gnt;
        end else if (window) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = cnt - CNT_W'(1);
        end

        if (if_req && !if_gnt) begin
            if (!if_force) begin
                starve_nxt = starve_cnt + SW'(1);
            end
        end else begin
            starve_nxt = '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed stimulus for mem_port_arbiter with a queue-based read-data scoreboard.
// Latency: the bench memory returns data two cycles after a read strobe.
// Backpressure: requests are held until granted, then dropped by the stimulus.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_fetch;
    logic        stall_mem;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_if_q[$];
    logic [15:0] exp_dm_q[$];

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous read with two pipeline stages, preloaded during reset.
    logic [15:0] mem [0:1023];
    logic [15:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (rst) begin
            mem[10'h010] <= 16'hABCD;
            mem[10'h020] <= 16'h1111;
            mem[10'h030] <= 16'h3333;
            mem[10'h050] <= 16'h5555;
            mem[10'h100] <= 16'h2222;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
        rd_p1 <= mem[mem_addr[9:0]];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected read data whenever the DUT presents rvalid.
    always @(negedge clk) begin
        check("gnt_exclusive", {31'd0, if_gnt & dm_gnt}, 32'd0);
        if (if_rvalid) begin
            if (exp_if_q.size() == 0) begin
                check("if_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("if_rdata", {16'd0, if_rdata}, {16'd0, exp_if_q.pop_front()});
            end
        end else begin
            check("if_rdata_idle", {16'd0, if_rdata}, 32'd0);
        end
        if (dm_rvalid) begin
            if (exp_dm_q.size() == 0) begin
                check("dm_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("dm_rdata", {16'd0, dm_rdata}, {16'd0, exp_dm_q.pop_front()});
            end
        end else begin
            check("dm_rdata_idle", {16'd0, dm_rdata}, 32'd0);
        end
    end

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 16'h0050; dm_req = 1'b1; dm_we = 1'b0;
        dm_addr = 16'h0050; dm_wdata = 16'h0000;

        // 1. Reset with both requesting, then first grant goes to DM.
        for (int i = 0; i < 2; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
            check("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
            check("rst_mem_en", {31'd0, mem_en}, 32'd0);
            check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        end
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("first_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("first_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("first_mem_addr", {16'd0, mem_addr}, 32'h0050);
        exp_dm_q.push_back(16'h5555);
        next_cycle(); if_req = 1'b0; dm_req = 1'b0;
        repeat (3) next_cycle();

        // 2. Lone IF read.
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        check("t2_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("t2_mem_en", {31'd0, mem_en}, 32'd1);
        check("t2_mem_we", {31'd0, mem_we}, 32'd0);
        check("t2_mem_addr", {16'd0, mem_addr}, 32'h0010);
        exp_if_q.push_back(16'hABCD);
        next_cycle(); if_req = 1'b0; if_addr = 16'hFFFF;
        @(negedge clk);
        check("t2_stall_t1", {31'd0, stall_fetch}, 32'd1);
        check("t2_rvalid_t1", {31'd0, if_rvalid}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t2_rvalid_t2", {31'd0, if_rvalid}, 32'd1);
        check("t2_stall_t2", {31'd0, stall_fetch}, 32'd0);
        repeat (2) next_cycle();

        // 3. Simultaneous reads: DM first, IF granted in DM's completion cycle.
        if_req = 1'b1; if_addr = 16'h0020; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0100;
        @(negedge clk);
        check("t3_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("t3_if_gnt_t0", {31'd0, if_gnt}, 32'd0);
        check("t3_mem_addr_t0", {16'd0, mem_addr}, 32'h0100);
        check("t3_stall_fetch_t0", {31'd0, stall_fetch}, 32'd1);
        exp_dm_q.push_back(16'h2222);
        next_cycle(); dm_req = 1'b0;
        @(negedge clk);
        check("t3_if_gnt_t1", {31'd0, if_gnt}, 32'd0);
        check("t3_stall_fetch_t1", {31'd0, stall_fetch}, 32'd1);
        check("t3_stall_mem_t1", {31'd0, stall_mem}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("t3_dm_rvalid_t2", {31'd0, dm_rvalid}, 32'd1);
        check("t3_if_gnt_t2", {31'd0, if_gnt}, 32'd1);
        check("t3_mem_addr_t2", {16'd0, mem_addr}, 32'h0020);
        exp_if_q.push_back(16'h1111);
        next_cycle(); if_req = 1'b0;
        @(negedge clk);
        check("t3_stall_fetch_t3", {31'd0, stall_fetch}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("t3_if_rvalid_t4", {31'd0, if_rvalid}, 32'd1);
        repeat (2) next_cycle();

        // 4. Starvation: DM writes back-to-back, IF forced through after four denials.
        if_req = 1'b1; if_addr = 16'h0030; dm_req = 1'b1; dm_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            dm_addr = 16'h0300 + 16'(i); dm_wdata = 16'h7000 + 16'(i);
            @(negedge clk);
            check("t4_dm_gnt", {31'd0, dm_gnt}, 32'd1);
            check("t4_if_gnt", {31'd0, if_gnt}, 32'd0);
            check("t4_mem_we", {31'd0, mem_we}, 32'd1);
        end
        next_cycle();
        @(negedge clk);
        check("t4_if_forced", {31'd0, if_gnt}, 32'd1);
        check("t4_dm_denied", {31'd0, dm_gnt}, 32'd0);
        check("t4_mem_we_if", {31'd0, mem_we}, 32'd0);
        exp_if_q.push_back(16'h3333);
        next_cycle(); if_req = 1'b0;
        @(negedge clk);
        check("t4_dm_wait", {31'd0, dm_gnt}, 32'd0);
        check("t4_stall_mem", {31'd0, stall_mem}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("t4_dm_regnt", {31'd0, dm_gnt}, 32'd1);
        check("t4_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        next_cycle(); dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) next_cycle();

        // 5. DM write then pending IF read of the same address.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h5A5A;
        if_req = 1'b1; if_addr = 16'h0200;
        @(negedge clk);
        check("t5_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("t5_mem_we", {31'd0, mem_we}, 32'd1);
        check("t5_mem_addr", {16'd0, mem_addr}, 32'h0200);
        check("t5_mem_wdata", {16'd0, mem_wdata}, 32'h5A5A);
        next_cycle(); dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 16'h0000;
        @(negedge clk);
        check("t5_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("t5_mem_we_rd", {31'd0, mem_we}, 32'd0);
        exp_if_q.push_back(16'h5A5A);
        next_cycle(); if_req = 1'b0;
        repeat (3) next_cycle();

        // 6. Reset during an outstanding DM read discards it.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0100;
        @(negedge clk);
        check("t6_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        next_cycle(); rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        check("t6_rst_mem_en", {31'd0, mem_en}, 32'd0);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        check("t6_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        check("t6_stall_mem", {31'd0, stall_mem}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("t6_stall_mem_t3", {31'd0, stall_mem}, 32'd0);
        // Port is idle again: a fresh DM read is granted immediately.
        next_cycle(); dm_req = 1'b1; dm_addr = 16'h0050;
        @(negedge clk);
        check("t6_post_gnt", {31'd0, dm_gnt}, 32'd1);
        exp_dm_q.push_back(16'h5555);
        next_cycle(); dm_req = 1'b0;

        for (int i = 0; i < 20 && (exp_if_q.size() + exp_dm_q.size()) != 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        check("scoreboard_drain", exp_if_q.size() + exp_dm_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
